// File: rtl/load_align_pipe.sv
// load_align_pipe
//   Two-stage MIPS load-data aligner sitting between the data-memory read port
//   and the MEM/WB register. Stage 1 picks the addressed 32-bit word lane and
//   captures the op, byte offset, old rt value and tag. Stage 2 extracts,
//   extends or merges the result and holds it in the output register.
//   Ops handled: LB, LBU, LH, LHU, LW, LWL, LWR. Memory is big-endian, so
//   byte 0 of a word is its MSB.
//
// Build option
//   LOAD_ALIGN_MISALIGN_TRAP_EN
//     defined     : a misaligned LH/LHU/LW reports out_err[1]=1 with
//                   out_data=0. The load still uses a pipeline slot.
//     not defined : out_err[1] is always 0. A misaligned LH/LHU is forced to
//                   a half-word boundary, and a misaligned LW is forced to
//                   offset 0.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   flush                  drop every in-flight load at the next edge
//   in_valid / in_ready    input handshake (in_ready depends combinationally
//                          on out_ready and flush)
//   in_op                  opcode IR[31:26]
//   in_addr                low byte-address bits; with MEM_W=64, bit 2 picks
//                          the word lane
//   in_data                raw memory beat, byte 0 is the MSB
//   in_rt_old              current rt value, merged by LWL/LWR
//   in_tag                 sideband tag, passed through unchanged
//   out_valid / out_ready  output handshake
//   out_data               aligned/extended result
//   out_tag                tag belonging to out_data
//   out_err                {misalign, illegal_op}

module load_align_pipe #(
  parameter int MEM_W = 32,
  parameter int TAG_W = 5,
  parameter int AL_W  = $clog2(MEM_W / 8)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_op,
  input  logic [AL_W-1:0]  in_addr,
  input  logic [MEM_W-1:0] in_data,
  input  logic [31:0]      in_rt_old,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       out_err
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LWL = 6'b100010;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LWR = 6'b100110;

  // ---------------------------------------------------------------------------
  // Word-lane selection (input side of stage 1)
  // ---------------------------------------------------------------------------
  logic [31:0] lane_word;

  generate
    if (MEM_W == 64) begin : g_lane64
      assign lane_word = in_addr[2] ? in_data[31:0] : in_data[63:32];
    end else begin : g_lane32
      assign lane_word = in_data[31:0];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_word_q,  s1_word_d;
  logic [1:0]       s1_k_q,     s1_k_d;
  logic [5:0]       s1_op_q,    s1_op_d;
  logic [31:0]      s1_rt_q,    s1_rt_d;
  logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q,  out_data_d;
  logic [TAG_W-1:0] out_tag_q,   out_tag_d;
  logic [1:0]       out_err_q,   out_err_d;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s2_load;
  logic s1_adv;
  logic in_accept;

  // Stage 2 can take a new entry when it is empty or is being drained this
  // cycle. Stage 1 moves forward only into a stage 2 that is loading.
  assign s2_load   = ~out_valid_q | out_ready;
  assign s1_adv    = s1_valid_q & s2_load;
  assign in_ready  = ~flush & (~s1_valid_q | s2_load);
  assign in_accept = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // Stage 1 next state
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_word_d  = s1_word_q;
    s1_k_d     = s1_k_q;
    s1_op_d    = s1_op_q;
    s1_rt_d    = s1_rt_q;
    s1_tag_d   = s1_tag_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (in_accept) begin
      s1_valid_d = 1'b1;
      s1_word_d  = lane_word;
      s1_k_d     = in_addr[1:0];
      s1_op_d    = in_op;
      s1_rt_d    = in_rt_old;
      s1_tag_d   = in_tag;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 datapath: extract, extend, merge
  // ---------------------------------------------------------------------------
  logic        is_half;
  logic        is_word;
  logic [1:0]  k_eff;
  logic [4:0]  sh_l;
  logic [4:0]  sh_r;
  logic [31:0] byte_shift;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] res_data;
  logic        res_illegal;
  logic        res_mis;

  assign is_half = (s1_op_q == OP_LH) || (s1_op_q == OP_LHU);
  assign is_word = (s1_op_q == OP_LW);

`ifdef LOAD_ALIGN_MISALIGN_TRAP_EN
  assign k_eff   = s1_k_q;
  assign res_mis = (is_half & s1_k_q[0]) | (is_word & (s1_k_q != 2'd0));
`else
  // Without the trap, a misaligned access is snapped to its natural boundary.
  assign k_eff   = is_half ? {s1_k_q[1], 1'b0} :
                   is_word ? 2'd0 : s1_k_q;
  assign res_mis = 1'b0;
`endif

  // Shift amounts: left by 8k (LWL), right by 8(3-k) (byte pick and LWR).
  // For a 2-bit k, the value 3-k equals ~k.
  assign sh_l       = {k_eff, 3'b000};
  assign sh_r       = {~k_eff, 3'b000};
  assign byte_shift = s1_word_q >> sh_r;
  assign byte_val   = byte_shift[7:0];
  assign half_val   = k_eff[1] ? s1_word_q[15:0] : s1_word_q[31:16];

  always_comb begin
    res_data    = 32'h0;
    res_illegal = 1'b0;
    case (s1_op_q)
      OP_LB:   res_data = {{24{byte_val[7]}}, byte_val};
      OP_LBU:  res_data = {24'h0, byte_val};
      OP_LH:   res_data = {{16{half_val[15]}}, half_val};
      OP_LHU:  res_data = {16'h0, half_val};
      OP_LW:   res_data = s1_word_q;
      OP_LWL:  res_data = (s1_word_q << sh_l) |
                          (s1_rt_q & ~(32'hFFFF_FFFF << sh_l));
      OP_LWR:  res_data = (s1_word_q >> sh_r) |
                          (s1_rt_q & ~(32'hFFFF_FFFF >> sh_r));
      default: res_illegal = 1'b1;
    endcase
    if (res_mis) begin
      res_data = 32'h0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 next state
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    out_err_d   = out_err_q;
    if (flush) begin
      // A handshake on the same edge has already completed, so clearing the
      // output slot is safe.
      out_valid_d = 1'b0;
    end else if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = res_data;
        out_tag_d  = s1_tag_q;
        out_err_d  = {res_mis, res_illegal};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_word_q   <= 32'h0;
      s1_k_q      <= 2'd0;
      s1_op_q     <= 6'd0;
      s1_rt_q     <= 32'h0;
      s1_tag_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0;
      out_tag_q   <= '0;
      out_err_q   <= 2'b00;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_word_q   <= s1_word_d;
      s1_k_q      <= s1_k_d;
      s1_op_q     <= s1_op_d;
      s1_rt_q     <= s1_rt_d;
      s1_tag_q    <= s1_tag_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_load_align_pipe.sv
// Bench for load_align_pipe. A 32-bit-beat and a 64-bit-beat instance are
// driven in lock-step with the same op, offset, word, rt and tag.
// Outputs from both instances are compared with a queue-based reference model.
module tb_load_align_pipe;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LWL = 6'b100010;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LWR = 6'b100110;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [5:0]  in_op;
  logic [1:0]  in_addr32;
  logic [2:0]  in_addr64;
  logic [31:0] in_data32;
  logic [63:0] in_data64;
  logic [31:0] in_rt_old;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, in_ready64, out_valid64;
  logic [31:0] out_data32, out_data64;
  logic [4:0]  out_tag32, out_tag64;
  logic [1:0]  out_err32, out_err64;

  always #5 clk = ~clk;

  load_align_pipe #(.MEM_W(32), .TAG_W(5)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_op(in_op),
    .in_addr(in_addr32), .in_data(in_data32), .in_rt_old(in_rt_old),
    .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
    .out_data(out_data32), .out_tag(out_tag32), .out_err(out_err32)
  );

  load_align_pipe #(.MEM_W(64), .TAG_W(5)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_op(in_op),
    .in_addr(in_addr64), .in_data(in_data64), .in_rt_old(in_rt_old),
    .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .out_data(out_data64), .out_tag(out_tag64), .out_err(out_err64)
  );

  typedef struct {
    logic [31:0] d;
    logic [4:0]  tag;
    logic [1:0]  err;
    int          age;
  } exp_t;

  exp_t        q[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic        lane_sel = 1'b0;
  logic [31:0] junk = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  // Reference model. It works per byte: byte i of the word is its i-th byte
  // counting from the MSB.
  function automatic void model(input logic [5:0] op, input logic [1:0] k,
                                input logic [31:0] w, input logic [31:0] rt,
                                output logic [31:0] d, output logic [1:0] e);
    logic [7:0]  b[4];
    logic [15:0] h;
    int          kk;
    for (int i = 0; i < 4; i++) b[i] = w[31-8*i -: 8];
    d = 32'h0;
    e = 2'b00;
`ifdef LOAD_ALIGN_MISALIGN_TRAP_EN
    if (((op == OP_LH || op == OP_LHU) && k[0]) || (op == OP_LW && k != 2'd0)) begin
      e = 2'b10;
      return;
    end
`endif
    kk = int'(k) & 2;
    h  = {b[kk], b[kk+1]};
    case (op)
      OP_LB:   d = {{24{b[k][7]}}, b[k]};
      OP_LBU:  d = {24'h0, b[k]};
      OP_LH:   d = {{16{h[15]}}, h};
      OP_LHU:  d = {16'h0, h};
      OP_LW:   d = w;
      OP_LWL:  d = (w << (8*k)) | (rt & ((32'd1 << (8*k)) - 32'd1));
      OP_LWR:  d = (w >> (8*(3-k))) | (rt & ~(32'hFFFF_FFFF >> (8*(3-k))));
      default: e = 2'b01;
    endcase
  endfunction

  // One clock cycle. At the negedge the task first checks the current outputs
  // against the model, then drives the inputs for the next rising edge.
  task automatic step(input logic f, input logic ordy, input logic iv,
                      input logic [5:0] op, input logic [1:0] k,
                      input logic [31:0] w, input logic [31:0] rt,
                      input logic [4:0] tag, output logic acc);
    logic exp_v;
    int   n;
    exp_t e;
    @(negedge clk);
    foreach (q[i]) q[i].age = q[i].age + 1;
    // The oldest load appears at the output two edges after it is accepted.
    exp_v = (q.size() > 0) && (q[0].age >= 2);
    chk("out_valid32", out_valid32, exp_v);
    chk("out_valid64", out_valid64, exp_v);
    if (exp_v) begin
      chk("data32", out_data32, q[0].d);
      chk("tag32",  out_tag32,  q[0].tag);
      chk("err32",  out_err32,  q[0].err);
      chk("data64", out_data64, q[0].d);
      chk("tag64",  out_tag64,  q[0].tag);
      chk("err64",  out_err64,  q[0].err);
    end
    flush     = f;
    out_ready = ordy;
    #1;
    n = q.size();
    // The pipeline holds at most two loads. It takes a new one unless full
    // and stalled, or unless it is being flushed.
    chk("in_ready32", in_ready32, !f && (n < 2 || ordy));
    chk("in_ready64", in_ready64, !f && (n < 2 || ordy));
    if (exp_v && ordy) void'(q.pop_front());
    if (f) q.delete();
    in_valid  = iv;
    in_op     = op;
    in_addr32 = k;
    in_addr64 = {lane_sel, k};
    in_data32 = w;
    in_data64 = lane_sel ? {junk, w} : {w, junk};
    in_rt_old = rt;
    in_tag    = tag;
    #1;
    acc = iv && in_ready32;
    if (acc) begin
      model(op, k, w, rt, e.d, e.err);
      e.tag = tag;
      e.age = 0;
      q.push_back(e);
    end
  endtask

  task automatic idle(input logic ordy);
    logic a;
    step(1'b0, ordy, 1'b0, 6'd0, 2'd0, 32'h0, 32'h0, 5'd0, a);
  endtask

  task automatic directed(input string name, input logic [5:0] op, input logic [1:0] k,
                          input logic [31:0] w, input logic [31:0] rt,
                          input logic [31:0] exp_d, input logic [1:0] exp_e);
    logic a;
    step(1'b0, 1'b1, 1'b1, op, k, w, rt, 5'd7, a);
    chk({name, "_acc"}, a, 1'b1);
    idle(1'b1);
    chk({name, "_lat1"}, out_valid32, 1'b0);
    idle(1'b1);
    chk({name, "_lat2"}, out_valid32, 1'b1);
    chk({name, "_d32"}, out_data32, exp_d);
    chk({name, "_d64"}, out_data64, exp_d);
    chk({name, "_e32"}, out_err32, exp_e);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic        acc;
    logic [5:0]  op;
    int          sent;
    logic [5:0]  ops[7];
    ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 6'd0;
    in_addr32 = 2'd0; in_addr64 = 3'd0; in_data32 = 32'h0; in_data64 = 64'h0;
    in_rt_old = 32'h0; in_tag = 5'd0; out_ready = 1'b1;
    #3;
    chk("rst_out_valid", out_valid32, 1'b0);
    chk("rst_in_ready",  in_ready32,  1'b1);
    chk("rst_out_data",  out_data32,  32'h0);
    chk("rst_out_tag",   out_tag32,   5'd0);
    chk("rst_out_err",   out_err32,   2'b00);
    chk("rst_out_valid64", out_valid64, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases. Lane 1 with junk 01234567 gives the 64-bit beat
    // 64'h01234567_89ABCDEF for the LW case.
    lane_sel = 1'b0; junk = 32'hDEAD_BEEF;
    directed("lb",  OP_LB,  2'd1, 32'h12F4_5678, 32'h0, 32'hFFFF_FFF4, 2'b00);
    directed("lhu", OP_LHU, 2'd2, 32'h1234_8765, 32'h0, 32'h0000_8765, 2'b00);
    directed("lh",  OP_LH,  2'd2, 32'h1234_8765, 32'h0, 32'hFFFF_8765, 2'b00);
    lane_sel = 1'b1;
    directed("lwl", OP_LWL, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'hBBCC_DD44, 2'b00);
    directed("lwr", OP_LWR, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_AABB, 2'b00);
    junk = 32'h0123_4567;
    directed("lw64", OP_LW, 2'd0, 32'h89AB_CDEF, 32'h0, 32'h89AB_CDEF, 2'b00);
    directed("ill", 6'b000000, 2'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 2'b01);

    // Stream of four loads with a three-cycle output stall
    lane_sel = 1'b0;
    sent = 0;
    for (int c = 0; c < 12; c++) begin
      step(1'b0, !(c >= 2 && c <= 4), sent < 4, OP_LW, 2'd0,
           32'hC0DE_0000 + 32'(sent), 32'h0, 5'(sent), acc);
      if (acc) sent++;
      if (c == 3) chk("stall_in_ready", in_ready32, 1'b0);
      if (c == 4) chk("stall_hold", out_data32, 32'hC0DE_0000);
    end
    chk("stall_sent", sent, 4);

    // Flush with two loads in flight and a concurrent input beat
    step(1'b0, 1'b1, 1'b1, OP_LB, 2'd0, 32'h1111_1111, 32'h0, 5'd1, acc);
    step(1'b0, 1'b1, 1'b1, OP_LB, 2'd1, 32'h2222_2222, 32'h0, 5'd2, acc);
    step(1'b1, 1'b0, 1'b1, OP_LB, 2'd2, 32'h3333_3333, 32'h0, 5'd3, acc);
    chk("flush_drop_in", acc, 1'b0);
    idle(1'b1);
    chk("flush_nov1", out_valid32, 1'b0);
    idle(1'b1);
    chk("flush_nov2", out_valid32, 1'b0);
`ifdef LOAD_ALIGN_MISALIGN_TRAP_EN
    directed("lw_mis", OP_LW, 2'd2, 32'hCAFE_F00D, 32'h0, 32'h0, 2'b10);
`else
    directed("lw_mis", OP_LW, 2'd2, 32'hCAFE_F00D, 32'h0, 32'hCAFE_F00D, 2'b00);
`endif
    idle(1'b1);
    idle(1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      lane_sel = 1'($urandom);
      junk     = $urandom;
      op       = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      step($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0, op, 2'($urandom), $urandom, $urandom,
           5'($urandom), acc);
    end
    for (int i = 0; i < 6; i++) idle(1'b1);
    chk("drain_empty", q.size(), 0);

    // Asynchronous reset while loads are in flight
    step(1'b0, 1'b0, 1'b1, OP_LBU, 2'd3, 32'h0102_0304, 32'h0, 5'd9, acc);
    step(1'b0, 1'b0, 1'b1, OP_LBU, 2'd2, 32'h0102_0304, 32'h0, 5'd10, acc);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid32, 1'b0);
    chk("arst_out_data",  out_data32,  32'h0);
    chk("arst_in_ready",  in_ready32,  1'b1);
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
